// File: rtl/bf16_mul_arbiter.sv
// Round-robin sharing of one BF16 multiplier; result at rsp 1+MUL_LAT cycles after issue.
// Backpressure: issue is credit-gated by in-flight plus queued results, so rsp_ready stalls never drop data.
module bf16_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  output logic                  mul_in_valid,
  input  logic [15:0]           mul_o,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH + MUL_LAT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    scan_id;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               issue_ok;
  int                 scan;
  logic [CW-1:0]      inflight_cnt;
  logic [CW-1:0]      fifo_cnt;
  logic [MUL_LAT-1:0] pipe_vld;
  logic [ID_W-1:0]    pipe_id [MUL_LAT];
  logic [ID_W-1:0]    mem_id  [FIFO_DEPTH];
  logic [15:0]        mem_dat [FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               push;
  logic               pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight_cnt = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      inflight_cnt = inflight_cnt + CW'(pipe_vld[k]);
    end
  end

  // Credit uses registered counts only, so a pop frees a slot one cycle later.
  assign issue_ok = (inflight_cnt + fifo_cnt) < CW'(FIFO_DEPTH);

  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    found   = 1'b0;
    scan    = 0;
    scan_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scan_id = scan[ID_W-1:0];
      if (issue_ok && !found && req_valid[scan_id]) begin
        found         = 1'b1;
        grant[scan_id] = 1'b1;
        gnt_id        = scan_id;
      end
    end
  end

  // Gating with rst_n keeps every output low while reset is asserted.
  assign req_ready    = grant & {NUM_REQ{rst_n}};
  assign mul_in_valid = |req_ready;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) begin
        mul_a = req_a[16*k +: 16];
        mul_b = req_b[16*k +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (mul_in_valid) begin
      ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int k = 0; k < MUL_LAT; k++) pipe_id[k] <= '0;
    end else begin
      pipe_vld[0] <= mul_in_valid;
      pipe_id[0]  <= gnt_id;
      for (int k = 1; k < MUL_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end
    end
  end

  assign push      = pipe_vld[MUL_LAT-1];
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]  <= pipe_id[MUL_LAT-1];
      mem_dat[wr_ptr] <= mul_o;
    end
  end

  assign rsp_id   = rsp_valid ? mem_id[rd_ptr]  : '0;
  assign rsp_data = rsp_valid ? mem_dat[rd_ptr] : '0;
  assign busy     = (inflight_cnt != '0) | (fifo_cnt != '0);

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Bench for bf16_mul_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_bf16_mul_arbiter;
  localparam int N = 4, LAT = 1, DEPTH = 4, IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic [15:0]     mul_a, mul_b, mul_o;
  logic            mul_in_valid;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [15:0]     rsp_data;
  logic            rsp_ready;
  logic            busy;

  bf16_mul_arbiter #(.NUM_REQ(N), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid),
    .mul_o(mul_o), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Normal-range BF16 multiply with truncation; operands are kept far from overflow.
  function automatic logic [15:0] bmul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    logic [6:0]  fr;
    int          e;
    p = {8'b0, 1'b1, a[6:0]} * {8'b0, 1'b1, b[6:0]};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (p[15]) begin e = e + 1; fr = p[14:8]; end
    else fr = p[13:7];
    return {a[15] ^ b[15], e[7:0], fr};
  endfunction

  logic [15:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= bmul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_o = mpipe[LAT-1];

  typedef struct { int id; logic [15:0] d; int rem; } fl_t;
  typedef struct { int id; logic [15:0] d; } rs_t;
  fl_t infl[$];
  rs_t fq[$];
  int  m_ptr;
  int  n_chk = 0, n_fail = 0;
  int  n_issued = 0, n_popped = 0;
  logic [N-1:0] obs_rr;
  int  obs_pop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rnd_bf();
    logic [7:0] e;
    e = 8'(110 + $urandom_range(0, 30));
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  task automatic model_clear();
    infl.delete();
    fq.delete();
    m_ptr = 0;
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    int g;
    int idx;
    fl_t nq[$];
    logic [15:0] ea, eb;
    #1;
    g = -1;
    if (infl.size() + fq.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    ea = (g >= 0) ? req_a[16*g +: 16] : 16'h0;
    eb = (g >= 0) ? req_b[16*g +: 16] : 16'h0;
    check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("mul_in_valid", 32'(mul_in_valid), 32'(g >= 0));
    check("mul_a", 32'(mul_a), 32'(ea));
    check("mul_b", 32'(mul_b), 32'(eb));
    check("rsp_valid", 32'(rsp_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      check("rsp_id", 32'(rsp_id), 32'(fq[0].id));
      check("rsp_data", 32'(rsp_data), 32'(fq[0].d));
    end
    check("busy", 32'(busy), 32'(infl.size() + fq.size() != 0));
    obs_rr  = req_ready;
    obs_pop = (rsp_valid && rsp_ready) ? int'(rsp_id) : -1;
    if (fq.size() != 0 && rsp_ready) begin
      void'(fq.pop_front());
      n_popped++;
    end
    foreach (infl[i]) begin
      if (infl[i].rem == 1) fq.push_back('{infl[i].id, infl[i].d});
      else nq.push_back('{infl[i].id, infl[i].d, infl[i].rem - 1});
    end
    infl = nq;
    if (g >= 0) begin
      infl.push_back('{g, bmul(ea, eb), LAT});
      m_ptr = (g + 1) % N;
      n_issued++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && (infl.size() + fq.size() != 0); i++) cycle();
    check("drained", 32'(infl.size() + fq.size()), 32'd0);
  endtask

  initial begin
    int hs;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    model_clear();
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid = '1;
    #1;
    check("rst_gate_ready", 32'(req_ready), 32'd0);
    check("rst_mul_in_valid", 32'(mul_in_valid), 32'd0);
    req_valid = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single op: 1.0 * 2.0
    req_valid = 4'b0001; req_a[15:0] = 16'h3F80; req_b[15:0] = 16'h4000; rsp_ready = 1'b1;
    cycle();
    check("t1_grant", 32'(obs_rr), 32'd1);
    req_valid = '0;
    cycle();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    check("t1_rsp_data", 32'(rsp_data), 32'h4000);
    cycle();
    check("t1_busy_low", 32'(busy), 32'd0);

    // All requesters valid: strict rotation starting after requester 0
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = rnd_bf(); req_b[16*i +: 16] = rnd_bf();
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("t2_rotation", 32'(obs_rr), 32'd1 << ((1 + k) % N));
    end
    drain();

    // Stalled consumer: exactly DEPTH handshakes, resume one cycle after first pop
    req_valid = '1; rsp_ready = 1'b0; hs = 0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (obs_rr != '0) hs++;
    end
    check("t3_handshakes", 32'(hs), DEPTH);
    rsp_ready = 1'b1;
    cycle();
    check("t3_no_issue_at_pop", 32'(obs_rr != '0), 32'd0);
    check("t3_popped", 32'(obs_pop >= 0), 32'd1);
    cycle();
    check("t3_resume", 32'(obs_rr != '0), 32'd1);

    // Reset in the middle of traffic with results queued and in flight
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_ready", 32'(req_ready), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    cycle();
    check("t6_first_grant", 32'(obs_rr), 32'd1);
    req_valid = '0;
    for (int k = 0; k < 3; k++) cycle();

    // Pointer at 1, only requesters 2 and 0 asking
    req_valid = 4'b0101;
    cycle();
    check("t5_first", 32'(obs_rr), 32'b0100);
    cycle();
    check("t5_second", 32'(obs_rr), 32'b0001);
    req_valid = '1;
    cycle();
    check("t5_ptr_at_1", 32'(obs_rr), 32'b0010);
    drain();

    // Continuous issue with an always-ready consumer, then random traffic
    n_issued = 0; n_popped = 0;
    req_valid = '1; rsp_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < N; i++) begin
        req_a[16*i +: 16] = rnd_bf(); req_b[16*i +: 16] = rnd_bf();
      end
      cycle();
    end
    for (int k = 0; k < 300; k++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        req_a[16*i +: 16] = rnd_bf(); req_b[16*i +: 16] = rnd_bf();
      end
      cycle();
    end
    drain();
    check("t4_no_loss", 32'(n_popped), 32'(n_issued));
    check("t4_busy_end", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
